// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end of the 16-bit Harvard core: drives the PC into the synchronous
// instruction ROM, registers the fetched word and splits it into fields for execute.
module fetch_decode_unit #(
  parameter int               PC_W     = 10,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter int               NUM_OPS  = 18,
  parameter logic [5:0]       HALT_OP  = 6'h3F
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_en,
  input  logic [15:0]     imem_rdata,
  input  logic            dec_stall,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  output logic            dec_valid,
  output logic [5:0]      op_sel,
  output logic [2:0]      rd,
  output logic [2:0]      rs,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] dec_pc,
  output logic            illegal,
  output logic            halted
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  localparam logic [6:0] L_NUM_OPS = 7'(NUM_OPS);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_f_pc;
  logic            r_f_valid;
  logic            r_dec_valid;
  logic [5:0]      r_op;
  logic [2:0]      r_rd;
  logic [2:0]      r_rs;
  logic [15:0]     r_imm;
  logic [PC_W-1:0] r_dec_pc;
  logic            r_illegal;
  logic            r_halted;

  logic [5:0]      w_op;
  logic            w_is_halt;
  logic            w_is_illegal;
  logic            w_imem_en;
  logic [PC_W-1:0] w_imem_addr;

  assign w_op         = imem_rdata[15:10];
  assign w_is_halt    = r_f_valid && (w_op == HALT_OP);
  assign w_is_illegal = ({1'b0, w_op} >= L_NUM_OPS) && (w_op != HALT_OP);

  // A HALT sitting in the fetch register must stop the next read so pc stays just past it.
  always_comb begin
    w_imem_en   = 1'b0;
    w_imem_addr = r_pc;
    case (r_state)
      S_BOOT: w_imem_en = 1'b1;
      S_RUN: begin
        if (br_valid) begin
          w_imem_en   = 1'b1;
          w_imem_addr = br_target;
        end else begin
          w_imem_en = !dec_stall && !w_is_halt;
        end
      end
      default: w_imem_en = 1'b0;
    endcase
  end

  // BOOT is the reset state, so the enable is masked while reset is held.
  assign imem_en   = w_imem_en & rst_n;
  assign imem_addr = w_imem_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_f_pc      <= '0;
      r_f_valid   <= 1'b0;
      r_dec_valid <= 1'b0;
      r_op        <= '0;
      r_rd        <= '0;
      r_rs        <= '0;
      r_imm       <= '0;
      r_dec_pc    <= '0;
      r_illegal   <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        S_BOOT: begin
          r_pc      <= r_pc + 1'b1;
          r_f_pc    <= r_pc;
          r_f_valid <= 1'b1;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          if (br_valid) begin
            r_pc        <= br_target + 1'b1;
            r_f_pc      <= br_target;
            r_f_valid   <= 1'b1;
            r_dec_valid <= 1'b0;
          end else if (!dec_stall) begin
            if (r_f_valid) begin
              r_rd     <= imem_rdata[9:7];
              r_rs     <= imem_rdata[6:4];
              r_imm    <= {{12{imem_rdata[3]}}, imem_rdata[3:0]};
              r_dec_pc <= r_f_pc;
              if (w_is_halt) begin
                r_dec_valid <= 1'b0;
                r_op        <= '0;
                r_halted    <= 1'b1;
                r_state     <= S_HALT;
              end else if (w_is_illegal) begin
                // Out-of-range codes never reach the downstream mux select.
                r_dec_valid <= 1'b0;
                r_op        <= '0;
                r_illegal   <= 1'b1;
              end else begin
                r_dec_valid <= 1'b1;
                r_op        <= w_op;
              end
            end else begin
              r_dec_valid <= 1'b0;
            end
            if (!w_is_halt) begin
              r_pc   <= r_pc + 1'b1;
              r_f_pc <= r_pc;
            end
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign dec_valid = r_dec_valid;
  assign op_sel    = r_op;
  assign rd        = r_rd;
  assign rs        = r_rs;
  assign imm       = r_imm;
  assign dec_pc    = r_dec_pc;
  assign illegal   = r_illegal;
  assign halted    = r_halted;

endmodule
